io_bridge_fx: RTL and testbench
===============================

Name: io_bridge_fx

Overview:
- Responder on the fixed-point core's IO bus. It services the core's input-read strobe (req_in/addr_in → io_in) and output-write strobe (out_en/addr_out/data_out).
- Input side: per-channel holding registers, loaded by external producers over a valid/ready handshake.
- Output side: core writes are queued into a tagged FIFO and drained by an external consumer over a valid/ready handshake.
- Sits between the core's IO pins and the system's sensors/actuators.

Parameters:
- NUBITS, 32, data word width; matches core data width.
- NUIOIN, 8, number of input channels (≥2).
- NUIOOU, 8, number of output addresses (≥2).
- FDEPTH, 3, log2 of output FIFO depth (depth = 8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_in  in  1  core input-read strobe, one cycle per read.
- addr_in  in  $clog2(NUIOIN)  input channel selected by core.
- io_in  out  NUBITS  read data to core.
- out_en  in  1  core output-write strobe.
- addr_out  in  $clog2(NUIOOU)  output address from core.
- data_out  in  NUBITS  write data from core.
- src_valid  in  1  producer offers a word.
- src_chan  in  $clog2(NUIOIN)  target input channel.
- src_data  in  NUBITS  producer word.
- src_ready  out  1  selected channel can accept a word.
- snk_valid  out  1  FIFO head valid.
- snk_ready  in  1  consumer accepts head.
- snk_data  out  NUBITS  FIFO head data.
- snk_addr  out  $clog2(NUIOOU)  FIFO head address tag.
- ch_full  out  NUIOIN  per-channel holding-register-valid mask.
- fifo_cnt  out  FDEPTH+1  output FIFO occupancy.
- ovf  out  1  sticky output-FIFO overflow flag.
- udf  out  1  sticky input-underflow flag.
- clr_flags  in  1  synchronous clear of ovf and udf.

Behaviour:
- Reset (rst=0, async):
  - all holding registers = 0; ch_full = 0;
  - FIFO pointers = 0; fifo_cnt = 0; snk_valid = 0;
  - ovf = udf = 0.
  - snk_data/snk_addr are don't-care while snk_valid=0; the bench must not check them.
  - Reset mid-transfer discards all queued and held data.
- Input read path (combinational):
  - io_in = hold[addr_in] at all times, zero latency, so the core samples it in the same cycle it asserts req_in.
  - addr_in ≥ NUIOIN returns 0.
- Input consume, on the clock edge with req_in=1:
  - ch_full[addr_in] clears.
  - If ch_full[addr_in] was already 0, io_in returns the stale held value and udf sets.
- Input load:
  - src_ready = ~ch_full[src_chan] | (req_in & addr_in==src_chan).
  - On an edge with src_valid & src_ready: hold[src_chan] ← src_data and ch_full[src_chan] ← 1.
- Load and consume on the same channel in the same cycle: the core reads the old value, the new value is stored, ch_full stays 1, and udf is unaffected unless the channel was empty.
- Output FIFO (show-ahead):
  - snk_valid = (fifo_cnt≠0); snk_data/snk_addr = head entry.
  - pop = snk_valid & snk_ready.
  - push = out_en & (fifo_cnt<2^FDEPTH | pop).
  - Pointers wrap modulo 2^FDEPTH.
  - fifo_cnt increments on push only, decrements on pop only, unchanged on both.
  - out_en while full with no pop: the write is dropped, ovf sets, FIFO contents are unchanged.
  - Push into an empty FIFO: snk_valid asserts on the next cycle (1-cycle latency).
- Flags:
  - ovf and udf are sticky until clr_flags=1.
  - If clr_flags coincides with a new overflow/underflow event, the set wins.
- No internal state machine beyond the FIFO control and per-channel valid bits; all state is updated only on the rising edge of clk, except the asynchronous reset.

Test Plan:
- Reset check: assert rst=0 mid-stream with FIFO cnt=3 and ch_full=8'h05 → immediately fifo_cnt=0, ch_full=0, snk_valid=0, ovf=udf=0, io_in=0.
- Input load/read: load chan 2 with 32'h0000_00C0; next cycle req_in with addr_in=2 → io_in=32'h0000_00C0 in that cycle, ch_full[2] clears at the edge, udf=0.
- Read of an empty channel: req_in with addr_in=5 and ch_full[5]=0 → io_in=0 (reset value), udf=1 and stays 1 until clr_flags pulse → 0.
- Simultaneous load and consume: chan 3 holds 11, same cycle src_valid with chan 3 and data 22 plus req_in with addr_in=3 → io_in=11, src_ready=1, next cycle hold[3]=22, ch_full[3]=1.
- FIFO order and tags: 3 core writes (addr 1,data 10), (4,20), (7,30) with snk_ready=0 → fifo_cnt=3; then snk_ready=1 → heads (1,10),(4,20),(7,30) in order, then snk_valid=0.
- FIFO full/overflow and wrap: 8 writes with snk_ready=0 → fifo_cnt=8; 9th write dropped and ovf=1; then a write with simultaneous pop is accepted and fifo_cnt stays 8; draining 20 mixed push/pop cycles preserves order across the pointer wrap.

Source files
------------

// File: rtl/io_bridge_fx.sv
// IO bridge for the fixed-point core: per-channel input holding registers with
// zero-latency read, and a tagged show-ahead output FIFO toward an external consumer.
module io_bridge_fx #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_in,
  input  logic [$clog2(NUIOIN)-1:0] addr_in,
  output logic [NUBITS-1:0]         io_in,
  input  logic                      out_en,
  input  logic [$clog2(NUIOOU)-1:0] addr_out,
  input  logic [NUBITS-1:0]         data_out,
  input  logic                      src_valid,
  input  logic [$clog2(NUIOIN)-1:0] src_chan,
  input  logic [NUBITS-1:0]         src_data,
  output logic                      src_ready,
  output logic                      snk_valid,
  input  logic                      snk_ready,
  output logic [NUBITS-1:0]         snk_data,
  output logic [$clog2(NUIOOU)-1:0] snk_addr,
  output logic [NUIOIN-1:0]         ch_full,
  output logic [FDEPTH:0]           fifo_cnt,
  output logic                      ovf,
  output logic                      udf,
  input  logic                      clr_flags
);

  localparam int AIW   = $clog2(NUIOIN);
  localparam int AOW   = $clog2(NUIOOU);
  localparam int NSLOT = 1 << AIW;
  localparam int FSIZE = 1 << FDEPTH;
  localparam logic [FDEPTH:0] C_FULL = FSIZE[FDEPTH:0];

  // Slots at or above NUIOIN are never loaded, so out-of-range reads return 0.
  logic [NUBITS-1:0] r_hold [NSLOT];
  logic [NSLOT-1:0]  r_full;
  logic              w_src_ready;
  logic              w_udf_set;

  assign io_in       = r_hold[addr_in];
  assign w_src_ready = ~r_full[src_chan] | (req_in & (addr_in == src_chan));
  assign src_ready   = w_src_ready;
  assign ch_full     = r_full[NUIOIN-1:0];
  assign w_udf_set   = req_in & ~r_full[addr_in];

  // A load wins over a consume on the same channel, keeping the valid bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NSLOT; i++) r_hold[i] <= '0;
      r_full <= '0;
    end else begin
      for (int unsigned i = 0; i < NUIOIN; i++) begin
        if (src_valid && w_src_ready && (src_chan == AIW'(i))) begin
          r_hold[i] <= src_data;
          r_full[i] <= 1'b1;
        end else if (req_in && (addr_in == AIW'(i))) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  logic [NUBITS-1:0] r_mem_d [FSIZE];
  logic [AOW-1:0]    r_mem_a [FSIZE];
  logic [FDEPTH-1:0] r_wp;
  logic [FDEPTH-1:0] r_rp;
  logic [FDEPTH:0]   r_cnt;
  logic              r_ovf;
  logic              r_udf;
  logic              w_pop;
  logic              w_push;

  assign w_pop  = (r_cnt != '0) & snk_ready;
  assign w_push = out_en & ((r_cnt != C_FULL) | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_d[r_wp] <= data_out;
      r_mem_a[r_wp] <= addr_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      r_ovf <= (out_en & ~w_push) | (r_ovf & ~clr_flags);
      r_udf <= w_udf_set | (r_udf & ~clr_flags);
    end
  end

  assign snk_valid = (r_cnt != '0);
  assign snk_data  = r_mem_d[r_rp];
  assign snk_addr  = r_mem_a[r_rp];
  assign fifo_cnt  = r_cnt;
  assign ovf       = r_ovf;
  assign udf       = r_udf;

endmodule

// File: tb/tb_io_bridge_fx.sv
// Bench for io_bridge_fx: directed input-path tasks plus a queue scoreboard
// that checks every FIFO head popped by the consumer.
module tb_io_bridge_fx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_in = 1'b0;
  logic [2:0]  addr_in = '0;
  logic [31:0] io_in;
  logic        out_en = 1'b0;
  logic [2:0]  addr_out = '0;
  logic [31:0] data_out = '0;
  logic        src_valid = 1'b0;
  logic [2:0]  src_chan = '0;
  logic [31:0] src_data = '0;
  logic        src_ready;
  logic        snk_valid;
  logic        snk_ready = 1'b0;
  logic [31:0] snk_data;
  logic [2:0]  snk_addr;
  logic [7:0]  ch_full;
  logic [3:0]  fifo_cnt;
  logic        ovf;
  logic        udf;
  logic        clr_flags = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int n_pops = 0;
  int mcnt = 0;
  int seq = 0;
  logic [34:0] exp_q [$];

  io_bridge_fx #(.NUBITS(32), .NUIOIN(8), .NUIOOU(8), .FDEPTH(3)) dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
    .src_valid(src_valid), .src_chan(src_chan), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data), .snk_addr(snk_addr),
    .ch_full(ch_full), .fifo_cnt(fifo_cnt), .ovf(ovf), .udf(udf), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: any head accepted by the consumer must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && snk_valid && snk_ready) begin
      n_cmp++;
      n_pops++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_pop: got addr=%0d data=%0h, required no entry", snk_addr, snk_data);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if ({snk_addr, snk_data} !== e) begin
          n_err++;
          $display("FAIL sb_head: got addr=%0d data=%0h, required addr=%0d data=%0h",
                   snk_addr, snk_data, e[34:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_drive(input bit we, input logic [2:0] a, input logic [31:0] d, input bit rdy);
    bit pop, acc;
    out_en = we; addr_out = a; data_out = d; snk_ready = rdy;
    pop = (mcnt != 0) && rdy;
    acc = we && ((mcnt < 8) || pop);
    if (acc) exp_q.push_back({a, d});
    mcnt = mcnt + (acc ? 1 : 0) - (pop ? 1 : 0);
    tick();
    out_en = 1'b0; snk_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt: got %0d required 0", fifo_cnt); end
    n_cmp++; if (ch_full !== 8'h00) begin n_err++; $display("FAIL rst_full: got %0h required 0", ch_full); end
    n_cmp++; if (snk_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b required 0", snk_valid); end
    n_cmp++; if ({ovf, udf} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %0b required 00", {ovf, udf}); end
    n_cmp++; if (io_in !== 32'd0) begin n_err++; $display("FAIL rst_ioin: got %0h required 0", io_in); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_input_load();
    src_valid = 1'b1; src_chan = 3'd2; src_data = 32'h0000_00C0;
    #3;
    n_cmp++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL load_ready: got %0b required 1", src_ready); end
    tick();
    src_valid = 1'b0;
    n_cmp++; if (ch_full !== 8'h04) begin n_err++; $display("FAIL load_full: got %0h required 04", ch_full); end
    req_in = 1'b1; addr_in = 3'd2;
    #3;
    n_cmp++; if (io_in !== 32'h0000_00C0) begin n_err++; $display("FAIL load_read: got %0h required c0", io_in); end
    tick();
    req_in = 1'b0;
    n_cmp++; if (ch_full !== 8'h00) begin n_err++; $display("FAIL load_consume: got %0h required 00", ch_full); end
    n_cmp++; if (udf !== 1'b0) begin n_err++; $display("FAIL load_udf: got %0b required 0", udf); end
  endtask

  task automatic test_empty_read();
    req_in = 1'b1; addr_in = 3'd5;
    #3;
    n_cmp++; if (io_in !== 32'd0) begin n_err++; $display("FAIL empty_read: got %0h required 0", io_in); end
    tick();
    req_in = 1'b0;
    n_cmp++; if (udf !== 1'b1) begin n_err++; $display("FAIL empty_udf: got %0b required 1", udf); end
    tick(); tick();
    n_cmp++; if (udf !== 1'b1) begin n_err++; $display("FAIL udf_sticky: got %0b required 1", udf); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    n_cmp++; if (udf !== 1'b0) begin n_err++; $display("FAIL udf_clear: got %0b required 0", udf); end
  endtask

  task automatic test_simultaneous();
    src_valid = 1'b1; src_chan = 3'd3; src_data = 32'd11;
    tick();
    src_valid = 1'b0;
    n_cmp++; if (ch_full !== 8'h08) begin n_err++; $display("FAIL sim_pre: got %0h required 08", ch_full); end
    src_valid = 1'b1; src_chan = 3'd3; src_data = 32'd22; req_in = 1'b1; addr_in = 3'd3;
    #3;
    n_cmp++; if (io_in !== 32'd11) begin n_err++; $display("FAIL sim_read: got %0d required 11", io_in); end
    n_cmp++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL sim_ready: got %0b required 1", src_ready); end
    tick();
    src_valid = 1'b0; req_in = 1'b0;
    n_cmp++; if (ch_full !== 8'h08) begin n_err++; $display("FAIL sim_full: got %0h required 08", ch_full); end
    n_cmp++; if (io_in !== 32'd22) begin n_err++; $display("FAIL sim_new: got %0d required 22", io_in); end
    n_cmp++; if (udf !== 1'b0) begin n_err++; $display("FAIL sim_udf: got %0b required 0", udf); end
    src_chan = 3'd3;
    #3;
    n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL sim_busy: got %0b required 0", src_ready); end
    req_in = 1'b1;
    tick();
    req_in = 1'b0;
  endtask

  task automatic test_fifo_order();
    out_en = 1'b1; addr_out = 3'd1; data_out = 32'd10;
    #3;
    n_cmp++; if (snk_valid !== 1'b0) begin n_err++; $display("FAIL lat_pre: got %0b required 0", snk_valid); end
    exp_q.push_back({3'd1, 32'd10}); mcnt = 1;
    tick();
    out_en = 1'b0;
    n_cmp++; if (snk_valid !== 1'b1) begin n_err++; $display("FAIL lat_post: got %0b required 1", snk_valid); end
    fifo_drive(1'b1, 3'd4, 32'd20, 1'b0);
    fifo_drive(1'b1, 3'd7, 32'd30, 1'b0);
    n_cmp++; if (fifo_cnt !== 4'd3) begin n_err++; $display("FAIL ord_cnt: got %0d required 3", fifo_cnt); end
    n_pops = 0;
    for (int i = 0; i < 3; i++) fifo_drive(1'b0, 3'd0, 32'd0, 1'b1);
    n_cmp++; if (n_pops !== 3) begin n_err++; $display("FAIL ord_pops: got %0d required 3", n_pops); end
    n_cmp++; if (snk_valid !== 1'b0) begin n_err++; $display("FAIL ord_empty: got %0b required 0", snk_valid); end
  endtask

  task automatic test_fifo_full_wrap();
    for (int i = 0; i < 8; i++) fifo_drive(1'b1, 3'(i), 32'(100 + i), 1'b0);
    n_cmp++; if (fifo_cnt !== 4'd8) begin n_err++; $display("FAIL full_cnt: got %0d required 8", fifo_cnt); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL full_noovf: got %0b required 0", ovf); end
    fifo_drive(1'b1, 3'd5, 32'hDEAD, 1'b0);
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b required 1", ovf); end
    n_cmp++; if (fifo_cnt !== 4'd8) begin n_err++; $display("FAIL ovf_cnt: got %0d required 8", fifo_cnt); end
    fifo_drive(1'b1, 3'd6, 32'd200, 1'b1);
    n_cmp++; if (fifo_cnt !== 4'd8) begin n_err++; $display("FAIL pushpop_cnt: got %0d required 8", fifo_cnt); end
    seq = 300;
    for (int i = 0; i < 20; i++) begin
      fifo_drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'(seq), 1'($urandom_range(0, 1)));
      seq++;
    end
    for (int i = 0; i < 20 && mcnt != 0; i++) fifo_drive(1'b0, 3'd0, 32'd0, 1'b1);
    n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL drain_cnt: got %0d required 0", fifo_cnt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL drain_sb: got %0d left required 0", exp_q.size()); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %0b required 0", ovf); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) fifo_drive(1'b1, 3'd2, 32'(50 + i), 1'b0);
    src_valid = 1'b1; src_chan = 3'd0; src_data = 32'hA0;
    tick();
    src_chan = 3'd2; src_data = 32'hA2;
    tick();
    src_valid = 1'b0; addr_in = 3'd2;
    #1;
    n_cmp++; if (fifo_cnt !== 4'd3) begin n_err++; $display("FAIL mid_pre_cnt: got %0d required 3", fifo_cnt); end
    n_cmp++; if (ch_full !== 8'h05) begin n_err++; $display("FAIL mid_pre_full: got %0h required 05", ch_full); end
    rst = 1'b0;
    #1;
    exp_q.delete(); mcnt = 0;
    n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL mid_cnt: got %0d required 0", fifo_cnt); end
    n_cmp++; if (ch_full !== 8'h00) begin n_err++; $display("FAIL mid_full: got %0h required 00", ch_full); end
    n_cmp++; if (snk_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %0b required 0", snk_valid); end
    n_cmp++; if ({ovf, udf} !== 2'b00) begin n_err++; $display("FAIL mid_flags: got %0b required 00", {ovf, udf}); end
    n_cmp++; if (io_in !== 32'd0) begin n_err++; $display("FAIL mid_ioin: got %0h required 0", io_in); end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (snk_valid !== 1'b0) begin n_err++; $display("FAIL post_valid: got %0b required 0", snk_valid); end
  endtask

  initial begin
    test_reset();
    test_input_load();
    test_empty_read();
    test_simultaneous();
    test_fifo_order();
    test_fifo_full_wrap();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
